key_sw_io_device: RTL and testbench
===================================

# key_sw_io_device

Memory-mapped input device that lets the processor read the board's push-buttons and slide switches through the data-memory bus. It is the read-direction responder, the counterpart to the HEX/LEDR/LEDG output registers. It synchronizes and debounces KEY[3:0] and SW[9:0] and holds each stable value in a data register. Each input group has a Ready/Overrun/IE control register, and the block drives an interrupt request. It sits beside DataMemory and is decoded on the same address, write-enable and data buses that the pipeline register drives.

## Interface
- DBITS, 32, bus data/address width
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a new input value is accepted; must be ≥ 2
- KEY_RESET, 4'hF, KEY stable/synchronizer value after reset (buttons idle high)
- ADDR_KDATA, 32'hF0000010; ADDR_KCTRL, 32'hF0000110; ADDR_SDATA, 32'hF0000014; ADDR_SCTRL, 32'hF0000114
---
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high
- addr  in  DBITS  bus byte address
- rdEn  in  1  read strobe; read side effects occur on the edge where it is high
- wrtEn  in  1  write strobe
- dIn  in  DBITS  write data
- key  in  4  raw KEY pins, asynchronous
- sw  in  10  raw SW pins, asynchronous
- dOut  out  DBITS  read data, combinational from addr and registers
- hit  out  1  addr matches one of the four registers
- irq  out  1  interrupt request

## Operation
- Two-flop synchronizer per group: s1 <= pin, s2 <= s1.
- Debounce per group, counter width ceil(log2(DEBOUNCE_CYCLES)):
  - qualify = (s2 != stable) && (s1 == s2).
  - If qualify is false: cnt <= 0.
  - If qualify is true and cnt < D-1: cnt++.
  - If qualify is true and cnt == D-1: stable <= s2, cnt <= 0, and an event is raised.
- On an event: Ready <= 1, and Overrun <= Overrun | Ready (old value).
- Register map (bits not listed read 0):
  - KDATA: [3:0] = key stable.
  - SDATA: [9:0] = sw stable.
  - KCTRL/SCTRL: bit0 = Ready, bit2 = Overrun, bit8 = IE.
- Read of xDATA with rdEn: Ready <= 0. Overrun is unchanged.
- Write of xCTRL with wrtEn:
  - Ready is unaffected.
  - Overrun <= Overrun & dIn[2] (write 0 to clear; write 1 has no effect).
  - IE <= dIn[8].
- Writes to xDATA are ignored.
- Reads of xCTRL have no side effects.
- dOut = 0 when hit = 0.
- irq = (KReady & KIE) | (SReady & SIE).
- Simultaneous events on the same edge:
  - Event + xDATA read: Ready stays 1. Overrun is not set, because the read consumed the old value.
  - Event + xCTRL write clearing Overrun: the set wins when old Ready = 1.
  - rdEn and wrtEn both high: both actions apply.
- KEY and SW groups are fully independent.

## Timing
- Reset values:
  - KEY s1/s2/stable = KEY_RESET.
  - SW s1/s2/stable = 0.
  - cnt = 0.
  - Ready, Overrun, IE = 0 in both groups.
  - irq = 0; dOut = 0 for non-hit addresses.
- Reset asserted mid-count discards the pending change. If the pin still differs from the reset value, a fresh count starts after reset is released.
- Latency: a pin change settled before edge 1 makes stable, Ready and irq visible after edge D+2, i.e. edge 6 for D = 4.
- Glitch rejection: any s2 bounce (s1 != s2) or return to the stable value restarts the count at 0. A pulse shorter than D+1 cycles never updates stable.
- dOut and hit are combinational (no read latency). The Ready clear from a read is visible the cycle after the read edge.
- Counter never exceeds D-1; there is no wrap.

## Test plan
- Reset with key=4'hF, sw=0 -> KCTRL=0, SCTRL=0, KDATA=0xF, SDATA=0, irq=0. Hold 20 cycles with no events.
- D=4; sw 0→0x2A5 at edge 1 -> SDATA=0x2A5 and SCTRL=0x1 after edge 6, not before. Read SDATA with rdEn -> SCTRL=0 on next cycle.
- D=4; key toggles 4'hF→4'hE for 3 cycles, then back -> KDATA stays 0xF and KCTRL=0.
- Two key events with no read in between (0xE, then 0xC) -> KDATA=0xC, KCTRL=0x5. Write KCTRL=0x100 -> KCTRL=0x101, irq=1. Write KCTRL=0x000 -> irq=0.
- Event edge coincides with a KDATA read -> KCTRL bit0=1, bit2=0. Event coincides with a KCTRL write of 0 while Ready=1 -> Overrun=1.
- Reset asserted at cnt=2 with sw pending -> cnt=0, SDATA=0. Release with sw held -> SDATA updates D+2 edges later.

Source files
------------

// File: rtl/key_sw_io_device.sv
// Memory-mapped KEY/SW read device: synchronize, debounce, latch stable values,
// and expose data + Ready/Overrun/IE control registers with an interrupt.

module keySwDebounce #(
   parameter int          W     = 4,
   parameter int          D     = 4,
   parameter logic [W-1:0] RSTV = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] pin,
   output logic [W-1:0] stable,
   output logic         evt
);
   localparam int CW = (D > 2) ? $clog2(D) : 1;

   logic [W-1:0]  s1, s2;
   logic [CW-1:0] cnt;
   logic          qualify;

   assign qualify = (s2 != stable) && (s1 == s2);
   // evt is combinational so Ready can be set on the same edge stable updates
   assign evt     = qualify && (cnt == CW'(D - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         s1     <= RSTV;
         s2     <= RSTV;
         stable <= RSTV;
         cnt    <= '0;
      end else begin
         s1 <= pin;
         s2 <= s1;
         if (!qualify)
            cnt <= '0;
         else if (evt) begin
            stable <= s2;
            cnt    <= '0;
         end else
            cnt <= cnt + 1'b1;
      end
   end
endmodule

module keySwCtrl (
   input  logic clk,
   input  logic reset,
   input  logic evt,
   input  logic dataRead,
   input  logic ctrlWrite,
   input  logic ovrKeep,
   input  logic ieIn,
   output logic ready,
   output logic ovr,
   output logic ie
);
   always_ff @(posedge clk) begin
      if (reset) begin
         ready <= 1'b0;
         ovr   <= 1'b0;
         ie    <= 1'b0;
      end else begin
         if (evt)
            ready <= 1'b1;
         else if (dataRead)
            ready <= 1'b0;
         // a coincident data read consumed the old value, so no overrun then
         ovr <= (ctrlWrite ? (ovr & ovrKeep) : ovr) | (evt & ready & ~dataRead);
         if (ctrlWrite)
            ie <= ieIn;
      end
   end
endmodule

module key_sw_io_device #(
   parameter int               DBITS           = 32,
   parameter int               DEBOUNCE_CYCLES = 500000,
   parameter logic [3:0]       KEY_RESET       = 4'hF,
   parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
   parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
   parameter logic [DBITS-1:0] ADDR_SDATA      = 32'hF0000014,
   parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DBITS-1:0] addr,
   input  logic             rdEn,
   input  logic             wrtEn,
   input  logic [DBITS-1:0] dIn,
   input  logic [3:0]       key,
   input  logic [9:0]       sw,
   output logic [DBITS-1:0] dOut,
   output logic             hit,
   output logic             irq
);
   logic       selKData, selKCtrl, selSData, selSCtrl;
   logic [3:0] keyStable;
   logic [9:0] swStable;
   logic       keyEvt, swEvt;
   logic       kReady, kOvr, kIe, sReady, sOvr, sIe;
   logic       unusedDin;

   assign selKData  = (addr == ADDR_KDATA);
   assign selKCtrl  = (addr == ADDR_KCTRL);
   assign selSData  = (addr == ADDR_SDATA);
   assign selSCtrl  = (addr == ADDR_SCTRL);
   assign hit       = selKData | selKCtrl | selSData | selSCtrl;
   assign unusedDin = ^dIn;

   keySwDebounce #(.W(4), .D(DEBOUNCE_CYCLES), .RSTV(KEY_RESET)) uKeyDb (
      .clk(clk), .reset(reset), .pin(key), .stable(keyStable), .evt(keyEvt));

   keySwDebounce #(.W(10), .D(DEBOUNCE_CYCLES), .RSTV(10'h0)) uSwDb (
      .clk(clk), .reset(reset), .pin(sw), .stable(swStable), .evt(swEvt));

   keySwCtrl uKeyCtrl (
      .clk(clk), .reset(reset), .evt(keyEvt),
      .dataRead(rdEn & selKData), .ctrlWrite(wrtEn & selKCtrl),
      .ovrKeep(dIn[2]), .ieIn(dIn[8]),
      .ready(kReady), .ovr(kOvr), .ie(kIe));

   keySwCtrl uSwCtrl (
      .clk(clk), .reset(reset), .evt(swEvt),
      .dataRead(rdEn & selSData), .ctrlWrite(wrtEn & selSCtrl),
      .ovrKeep(dIn[2]), .ieIn(dIn[8]),
      .ready(sReady), .ovr(sOvr), .ie(sIe));

   assign irq = (kReady & kIe) | (sReady & sIe);

   always_comb begin
      dOut = '0;
      if (selKData)
         dOut[3:0] = keyStable;
      else if (selSData)
         dOut[9:0] = swStable;
      else if (selKCtrl) begin
         dOut[0] = kReady;
         dOut[2] = kOvr;
         dOut[8] = kIe;
      end else if (selSCtrl) begin
         dOut[0] = sReady;
         dOut[2] = sOvr;
         dOut[8] = sIe;
      end
   end
endmodule

// File: tb/tb_key_sw_io_device.sv
// Directed scoreboard bench for key_sw_io_device with a short debounce (D=4).

module tb_key_sw_io_device;
   localparam int D = 4;
   localparam logic [31:0] KDATA = 32'hF0000010, KCTRL = 32'hF0000110;
   localparam logic [31:0] SDATA = 32'hF0000014, SCTRL = 32'hF0000114;
   localparam logic [31:0] NOHIT = 32'hF0000018;

   logic        clk = 1'b0, reset = 1'b1;
   logic [31:0] addr = '0, dIn = '0, dOut;
   logic        rdEn = 1'b0, wrtEn = 1'b0, hit, irq;
   logic [3:0]  key = 4'hF;
   logic [9:0]  sw = '0;
   logic        mon = 1'b0;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        hit;
      logic        irq;
   } expT;
   expT sb[$];

   int total = 0, bad = 0;

   key_sw_io_device #(.DBITS(32), .DEBOUNCE_CYCLES(D), .KEY_RESET(4'hF)) dut (
      .clk(clk), .reset(reset), .addr(addr), .rdEn(rdEn), .wrtEn(wrtEn), .dIn(dIn),
      .key(key), .sw(sw), .dOut(dOut), .hit(hit), .irq(irq));

   always #5 clk = ~clk;

   // monitor: whenever a sample is presented, pop the expectation and compare
   always @(negedge clk) begin
      if (mon) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard-empty: sample with no expectation");
         end else begin
            expT e;
            e = sb.pop_front();
            if (dOut !== e.data || hit !== e.hit || irq !== e.irq) begin
               bad++;
               $display("FAIL %s: got dOut=%h hit=%b irq=%b want dOut=%h hit=%b irq=%b",
                        e.name, dOut, hit, irq, e.data, e.hit, e.irq);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // present addr (optionally with rdEn) for one cycle; consumes one clock edge
   task automatic chk(input string name, input logic [31:0] a, input logic rd,
                      input logic [31:0] exp, input logic expHit, input logic expIrq);
      expT e;
      e.name = name; e.data = exp; e.hit = expHit; e.irq = expIrq;
      sb.push_back(e);
      addr = a; rdEn = rd; mon = 1'b1;
      tick(1);
      mon = 1'b0; rdEn = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; dIn = d; wrtEn = 1'b1;
      tick(1);
      wrtEn = 1'b0; dIn = '0;
   endtask

   initial begin
      // reset and idle
      tick(3);
      reset = 1'b0;
      tick(20);
      chk("rst_kctrl", KCTRL, 0, 32'h0, 1, 0);
      chk("rst_sctrl", SCTRL, 0, 32'h0, 1, 0);
      chk("rst_kdata", KDATA, 0, 32'hF, 1, 0);
      chk("rst_sdata", SDATA, 0, 32'h0, 1, 0);
      chk("nohit",     NOHIT, 0, 32'h0, 0, 0);

      // SW change: visible only after the 6th edge
      sw = 10'h2A5;
      tick(4);
      chk("sw_e5",     SCTRL, 0, 32'h0,   1, 0);
      chk("sw_e6",     SCTRL, 0, 32'h0,   1, 0);
      chk("sw_ready",  SCTRL, 0, 32'h1,   1, 0);
      chk("sw_read",   SDATA, 1, 32'h2A5, 1, 0);
      chk("sw_clr",    SCTRL, 0, 32'h0,   1, 0);

      // 3-cycle KEY glitch is rejected
      key = 4'hE;
      tick(3);
      key = 4'hF;
      tick(10);
      chk("glitch_kdata", KDATA, 0, 32'hF, 1, 0);
      chk("glitch_kctrl", KCTRL, 0, 32'h0, 1, 0);

      // two events without a read -> overrun
      key = 4'hE;
      tick(8);
      key = 4'hC;
      tick(8);
      chk("ovr_kdata", KDATA, 0, 32'hC, 1, 0);
      chk("ovr_kctrl", KCTRL, 0, 32'h5, 1, 0);
      wr(KCTRL, 32'h100);
      chk("ie_on",     KCTRL, 0, 32'h101, 1, 1);
      wr(KCTRL, 32'h000);
      chk("ie_off",    KCTRL, 0, 32'h001, 1, 0);

      // event on the same edge as a KDATA read
      key = 4'h8;
      tick(5);
      chk("evrd_old",  KDATA, 1, 32'hC, 1, 0);
      chk("evrd_ctrl", KCTRL, 0, 32'h1, 1, 0);
      chk("evrd_new",  KDATA, 0, 32'h8, 1, 0);

      // event on the same edge as a KCTRL write of 0 while Ready=1
      key = 4'h0;
      tick(5);
      wr(KCTRL, 32'h000);
      chk("evwr_ctrl", KCTRL, 0, 32'h5, 1, 0);
      chk("evwr_data", KDATA, 0, 32'h0, 1, 0);

      // reset mid-count discards pending SW change; recount after release
      sw = 10'h155;
      tick(4);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("mrst_sdata", SDATA, 0, 32'h0, 1, 0);
      tick(3);
      chk("mrst_e5",    SCTRL, 0, 32'h0,   1, 0);
      chk("mrst_e6",    SCTRL, 0, 32'h0,   1, 0);
      chk("mrst_ready", SCTRL, 0, 32'h1,   1, 0);
      chk("mrst_data",  SDATA, 0, 32'h155, 1, 0);

      tick(2);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
